// File: rtl/alu_sequencer.sv
// Sequences single ALU operations, loads and branch tests, and owns accumulators A and B.
// Optional macro ALU_SEQ_BRANCH_EN compiles in the branch-test path (opcode 9); without it opcode 9 is illegal.
module alu_sequencer (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iValid,
  output logic       oReady,
  input  logic [3:0] iOp,
  input  logic       iDest,
  input  logic [7:0] iImm,
  input  logic [2:0] iCond,
  output logic [2:0] oALUControl,
  output logic       oRegOutputALU,
  output logic [7:0] oOpA,
  output logic [7:0] oOpB,
  input  logic [7:0] iALUOut,
  input  logic       iN_A,
  input  logic       iZ_A,
  input  logic       iC_A,
  input  logic       iN_B,
  input  logic       iZ_B,
  input  logic       iC_B,
  output logic [7:0] oAccA,
  output logic [7:0] oAccB,
  output logic       oDone,
  output logic       oTaken,
  output logic       oError
);

  // Request handshake: a request transfers on a rising edge where iValid && oReady;
  // oReady is high only in IDLE and iValid is ignored in every other state.
  typedef enum logic [1:0] {IDLE, EXEC, BRANCH, DONE} state_t;

  state_t     state, state_nxt;
  logic [2:0] alu_op_q;
  logic       dest_q;
  logic [7:0] imm_q;
  logic [7:0] acc_a, acc_b;
  logic       error_q;
  logic       accept;
  logic       is_alu, is_load, is_branch, is_legal;

  assign accept    = iValid && (state == IDLE);
  assign is_alu    = (iOp[3] == 1'b0) && (iOp[2:0] != 3'd7);
  assign is_load   = (iOp == 4'd8);
`ifdef ALU_SEQ_BRANCH_EN
  assign is_branch = (iOp == 4'd9);
`else
  assign is_branch = 1'b0;
`endif
  assign is_legal  = is_alu || is_load || is_branch;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    oReady      = 1'b0;
    oALUControl = 3'd7;
    oDone       = 1'b0;
    case (state)
      IDLE: begin
        oReady = 1'b1;
        if (iValid) begin
          if (is_alu)         state_nxt = EXEC;
          else if (is_branch) state_nxt = BRANCH;
          else                state_nxt = DONE;
        end
      end
      EXEC: begin
        oALUControl = alu_op_q;
        state_nxt   = DONE;
      end
      BRANCH: state_nxt = DONE;
      DONE: begin
        oDone     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulators change only on a load accept or at the edge closing EXEC.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      alu_op_q <= 3'd0;
      dest_q   <= 1'b0;
      imm_q    <= 8'd0;
      acc_a    <= 8'd0;
      acc_b    <= 8'd0;
      error_q  <= 1'b0;
    end else begin
      if (accept) begin
        alu_op_q <= iOp[2:0];
        dest_q   <= iDest;
        imm_q    <= iImm;
        error_q  <= !is_legal;
        if (is_load) begin
          if (iDest) acc_b <= iImm;
          else       acc_a <= iImm;
        end
      end
      if (state == EXEC) begin
        if (dest_q) acc_b <= iALUOut;
        else        acc_a <= iALUOut;
      end
    end
  end

`ifdef ALU_SEQ_BRANCH_EN
  logic [2:0] cond_q;
  logic       taken_q;
  logic       flag_n, flag_z, flag_c, cond_met;

  assign flag_n = dest_q ? iN_B : iN_A;
  assign flag_z = dest_q ? iZ_B : iZ_A;
  assign flag_c = dest_q ? iC_B : iC_A;

  always_comb begin
    cond_met = 1'b0;
    case (cond_q)
      3'd0: cond_met = flag_z;
      3'd1: cond_met = !flag_z;
      3'd2: cond_met = flag_c;
      3'd3: cond_met = !flag_c;
      3'd4: cond_met = flag_n;
      3'd5: cond_met = !flag_n;
      3'd6: cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cond_q  <= 3'd0;
      taken_q <= 1'b0;
    end else begin
      if (accept) begin
        cond_q  <= iCond;
        taken_q <= 1'b0;
      end
      if (state == BRANCH) taken_q <= cond_met;
    end
  end

  assign oTaken = (state == DONE) && taken_q;
`else
  logic unused_branch_inputs;
  assign unused_branch_inputs = ^{iCond, iN_A, iZ_A, iC_A, iN_B, iZ_B, iC_B};
  assign oTaken = 1'b0;
`endif

  assign oError        = (state == DONE) && error_q;
  assign oRegOutputALU = dest_q;
  assign oOpA          = dest_q ? acc_b : acc_a;
  assign oOpB          = imm_q;
  assign oAccA         = acc_a;
  assign oAccB         = acc_b;

endmodule
